// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared DMCtrl encoding, sequencer states and load-extension helpers
//
// Purpose: constants and helpers shared by the data-memory sequencer and the
// core decoder.
//   DM_*         DMCtrl load/store width codes
//   dm_state_e   sequencer states
//   dm_nbytes    number of byte-lane RAM cycles for a DMCtrl code
//   dm_ctrl_bad  DMCtrl codes that never name a legal access
//   dm_extend    sign/zero extension of an assembled little-endian load
package dmem_pkg;

  localparam logic [2:0] DM_LB  = 3'b000;
  localparam logic [2:0] DM_LH  = 3'b001;
  localparam logic [2:0] DM_LW  = 3'b010;
  localparam logic [2:0] DM_LBU = 3'b100;
  localparam logic [2:0] DM_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_LAST = 2'd2,
    ST_RESP = 2'd3
  } dm_state_e;

  function automatic logic [2:0] dm_nbytes(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic dm_ctrl_bad(input logic [2:0] ctrl);
    return (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111);
  endfunction

  function automatic logic [31:0] dm_extend(input logic [2:0] ctrl, input logic [31:0] raw);
    case (ctrl)
      DM_LB:   return {{24{raw[7]}}, raw[7:0]};
      DM_LH:   return {{16{raw[15]}}, raw[15:0]};
      DM_LBU:  return {24'h000000, raw[7:0]};
      DM_LHU:  return {16'h0000, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// rtl/dmem_rr_arb2.sv - two-requester round-robin arbiter with last-grant memory
//
// Purpose: picks one of two requesters; on a tie the one not granted last wins.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req_i[1:0]  bit 0 = cpu, bit 1 = dbg
//   update_i    strobe: the current grant was taken, remember it
//   grant_o     one-hot (or zero) combinational grant
module dmem_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  // Starts as "dbg last" so the cpu wins the first tie after reset.
  logic last_dbg_q;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_dbg_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg_q <= 1'b1;
    end else if (update_i) begin
      last_dbg_q <= grant_o[1];
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - two-port byte-serial sequencer in front of the data RAM
//
// Purpose: arbitrates cpu/dbg load-store requests round-robin and runs each
// accepted access as one RAM cycle per byte, little-endian, against a
// synchronous single-port byte RAM with one cycle of read latency.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req/ready              request and combinational accept
//   cpu_we/ctrl/addr/wdata     operands, stable while cpu_req is high
//   cpu_done/err/rdata         completion pulse, reject flag, registered load data
//   dbg_*                      same set for the debug/loader port
//   ram_addr/we/wdata/rdata    byte RAM port
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_ctrl,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  output logic              dbg_ready,
  input  logic              dbg_we,
  input  logic [2:0]        dbg_ctrl,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_done,
  output logic              dbg_err,
  output logic [31:0]       dbg_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  dm_state_e         state_q, state_d;
  logic              owner_q, owner_d;   // 1 = dbg owns the access in flight
  logic              we_q, we_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        n_q, n_d;
  logic [1:0]        k_q, k_d;
  logic              err_q, err_d;
  logic [31:0]       raw_q, raw_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;

  logic [1:0] grant;
  logic       accept;

  dmem_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({dbg_req, cpu_req}),
    .update_i (accept),
    .grant_o  (grant)
  );

  assign accept = (state_q == ST_IDLE) && (grant != 2'b00);

  // Operands of the winning port.
  logic              req_we;
  logic [2:0]        req_ctrl;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        req_n;
  logic [ADDR_W:0]   req_end;
  logic              req_err;

  assign req_we    = grant[1] ? dbg_we    : cpu_we;
  assign req_ctrl  = grant[1] ? dbg_ctrl  : cpu_ctrl;
  assign req_addr  = grant[1] ? dbg_addr  : cpu_addr;
  assign req_wdata = grant[1] ? dbg_wdata : cpu_wdata;
  assign req_n     = dm_nbytes(req_ctrl);

  // One extra bit catches an access whose last byte runs past the top of the RAM.
  assign req_end = {1'b0, req_addr[ADDR_W-1:0]} + (ADDR_W+1)'(req_n) - (ADDR_W+1)'(1);

  assign req_err = dm_ctrl_bad(req_ctrl)
                 || (req_we && req_ctrl[2])
                 || (req_addr[31:ADDR_W] != '0)
                 || req_end[ADDR_W];

  logic       last_k;
  logic       cap_en;
  logic [1:0] cap_idx;
  logic [31:0] raw_cap;

  assign last_k = ({1'b0, k_q} == (n_q - 3'd1));

  // Read data trails its address by one cycle, so XFER step k fills lane k-1
  // and LAST fills the final lane n-1.
  assign cap_en  = (state_q == ST_XFER) && !we_q && (k_q != 2'd0);
  assign cap_idx = (state_q == ST_LAST) ? (n_q[1:0] - 2'd1) : (k_q - 2'd1);

  always_comb begin
    raw_cap = raw_q;
    raw_cap[{cap_idx, 3'b000} +: 8] = ram_rdata;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    ctrl_d      = ctrl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    n_d         = n_q;
    k_d         = k_q;
    err_d       = err_q;
    raw_d       = raw_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = grant[1];
          we_d    = req_we;
          ctrl_d  = req_ctrl;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          n_d     = req_n;
          k_d     = 2'd0;
          raw_d   = 32'h0;
          err_d   = req_err;
          state_d = req_err ? ST_RESP : ST_XFER;
        end
      end
      ST_XFER: begin
        if (cap_en) begin
          raw_d = raw_cap;
        end
        if (last_k) begin
          k_d     = 2'd0;
          state_d = we_q ? ST_RESP : ST_LAST;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      ST_LAST: begin
        raw_d = raw_cap;
        if (owner_q) begin
          dbg_rdata_d = dm_extend(ctrl_q, raw_cap);
        end else begin
          cpu_rdata_d = dm_extend(ctrl_q, raw_cap);
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      ctrl_q      <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      n_q         <= 3'd1;
      k_q         <= 2'd0;
      err_q       <= 1'b0;
      raw_q       <= 32'h0;
      cpu_rdata_q <= 32'h0;
      dbg_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      ctrl_q      <= ctrl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      n_q         <= n_d;
      k_q         <= k_d;
      err_q       <= err_d;
      raw_q       <= raw_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  logic in_xfer;
  logic in_resp;

  assign in_xfer = (state_q == ST_XFER);
  assign in_resp = (state_q == ST_RESP);

  // ready is gated by rst_n so it reads 0 while reset is held, like every
  // other handshake output.
  assign cpu_ready = rst_n && accept && grant[0];
  assign dbg_ready = rst_n && accept && grant[1];

  assign cpu_done  = in_resp && !owner_q;
  assign dbg_done  = in_resp && owner_q;
  assign cpu_err   = cpu_done && err_q;
  assign dbg_err   = dbg_done && err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

  assign ram_addr  = in_xfer ? (addr_q + ADDR_W'(k_q)) : '0;
  assign ram_we    = in_xfer && we_q;
  assign ram_wdata = (in_xfer && we_q) ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int ADDR_W = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [2:0]  cpu_ctrl = 3'b000;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        cpu_ready, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [2:0]  dbg_ctrl = 3'b000;
  logic [31:0] dbg_addr = 32'h0, dbg_wdata = 32'h0;
  logic        dbg_ready, dbg_done, dbg_err;
  logic [31:0] dbg_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  dmem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_ctrl(cpu_ctrl),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_ready(dbg_ready), .dbg_we(dbg_we), .dbg_ctrl(dbg_ctrl),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_done(dbg_done), .dbg_err(dbg_err),
    .dbg_rdata(dbg_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM, one cycle read latency.
  logic [7:0] ram [128];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic err; logic [31:0] rdata; int cyc; } rsp_t;
  typedef struct { int addr; int data; int cyc; } wr_t;

  rsp_t        rsp_cpu[$];
  rsp_t        rsp_dbg[$];
  wr_t         wr_q[$];
  int          acc_log[$];
  logic [7:0]  ref_mem [128];
  logic [31:0] rd_model [2];
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Reference model: applied in accept order, which is the order the
  // single-ported RAM sees the accesses.
  task automatic model_accept(input int p, input logic we, input logic [2:0] c,
                              input logic [31:0] a, input logic [31:0] wd);
    int n;
    bit bad;
    rsp_t r;
    longint unsigned last;
    int unsigned v;
    n = (c[1:0] == 2'b00) ? 1 : (c[1:0] == 2'b01) ? 2 : 4;
    last = a;
    last = last + n - 1;
    bad = (c == 3) || (c == 6) || (c == 7) || (we && c >= 4) || (last > 127);
    if (!bad && we) begin
      for (int i = 0; i < n; i++) begin
        wr_q.push_back('{int'(a) + i, int'(wd[8*i +: 8]), cyc + 1 + i});
        ref_mem[int'(a) + i] = wd[8*i +: 8];
      end
    end
    if (!bad && !we) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (int'(ref_mem[int'(a) + i]) << (8 * i));
      if (c == 0 && v >= 128)   v = v - 256;
      if (c == 1 && v >= 32768) v = v - 65536;
      rd_model[p] = v;
    end
    r.err   = bad;
    r.rdata = rd_model[p];
    r.cyc   = cyc + (bad ? 1 : (we ? n + 1 : n + 2));
    if (p == 0) rsp_cpu.push_back(r); else rsp_dbg.push_back(r);
    acc_log.push_back(p);
  endtask

  // Called just after a rising edge; returns just after the edge that took the request.
  task automatic issue(input int p, input logic we, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] wd);
    bit got;
    got = 0;
    if (p == 0) begin
      cpu_req = 1; cpu_we = we; cpu_ctrl = c; cpu_addr = a; cpu_wdata = wd;
    end else begin
      dbg_req = 1; dbg_we = we; dbg_ctrl = c; dbg_addr = a; dbg_wdata = wd;
    end
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (p == 0 ? cpu_ready : dbg_ready) begin
        got = 1;
        model_accept(p, we, c, a, wd);
      end
    end
    if (!got) fail_now($sformatf("accept_port%0d", p));
    @(posedge clk); #1;
    if (p == 0) cpu_req = 0; else dbg_req = 0;
  endtask

  task automatic await_done(input int p, input string name, input logic exp_err,
                            input logic [31:0] exp_rdata);
    bit got;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (p == 0 ? cpu_done : dbg_done) begin
        got = 1;
        check({name, "_err"}, (p == 0) ? cpu_err : dbg_err, exp_err);
        check({name, "_rdata"}, (p == 0) ? cpu_rdata : dbg_rdata, exp_rdata);
      end
    end
    if (!got) fail_now(name);
    @(posedge clk); #1;
  endtask

  task automatic pop_check(input int p);
    rsp_t r;
    if ((p == 0 && rsp_cpu.size() == 0) || (p == 1 && rsp_dbg.size() == 0)) begin
      n_chk++;
      n_bad++;
      $display("FAIL done_port%0d: got done want no done", p);
    end else begin
      if (p == 0) r = rsp_cpu.pop_front(); else r = rsp_dbg.pop_front();
      check($sformatf("done_cycle_p%0d", p), cyc, r.cyc);
      check($sformatf("err_p%0d", p), (p == 0) ? cpu_err : dbg_err, r.err);
      check($sformatf("rdata_p%0d", p), (p == 0) ? cpu_rdata : dbg_rdata, r.rdata);
    end
  endtask

  // Monitor: decoupled from stimulus, consumes expectations as the DUT responds.
  wr_t we_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_ready && dbg_ready) check("ready_exclusive", 32'd1, 32'd0);
      if (cpu_done) pop_check(0);
      if (dbg_done) pop_check(1);
      if (ram_we) begin
        if (wr_q.size() == 0) begin
          n_chk++;
          n_bad++;
          $display("FAIL ram_we: got write at %h want none", ram_addr);
        end else begin
          we_e = wr_q.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(we_e.addr));
          check("wr_data", 32'(ram_wdata), 32'(we_e.data));
          check("wr_cycle", cyc, we_e.cyc);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_we"}, 32'(ram_we), 0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_dbg_rdata"}, dbg_rdata, 0);
    check({tag, "_done"}, {30'd0, cpu_done, dbg_done}, 0);
    check({tag, "_ready"}, {30'd0, cpu_ready, dbg_ready}, 0);
  endtask

  task automatic flush_model();
    rsp_cpu.delete();
    rsp_dbg.delete();
    wr_q.delete();
    rd_model[0] = 0;
    rd_model[1] = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic rand_op(input int p);
    logic [2:0]  c;
    logic        we;
    logic [31:0] a;
    int          r;
    r = $urandom_range(0, 19);
    if (r == 0) c = 3'b011;
    else if (r == 1) c = 3'b110 | 3'($urandom_range(0, 1));
    else c = (r % 5 == 0) ? DM_LB : (r % 5 == 1) ? DM_LH : (r % 5 == 2) ? DM_LW :
             (r % 5 == 3) ? DM_LBU : DM_LHU;
    we = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    if (r == 0) a = $urandom;
    else if (r == 1) a = 32'($urandom_range(124, 127));
    else a = 32'($urandom_range(0, 127));
    issue(p, we, c, a, $urandom);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
  endtask

  logic [31:0] old_word;
  bit          drained;

  initial begin
    rd_model[0] = 0;
    rd_model[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Fill the RAM through the debug port with byte stores.
    for (int i = 0; i < 128; i++) issue(1, 1'b1, DM_LB, 32'(i), $urandom);
    repeat (4) @(posedge clk);
    #1;
    do_reset();

    // Tie after reset: cpu, dbg, cpu.
    acc_log.delete();
    fork
      begin
        issue(0, 1'b0, DM_LW, 32'h0, 32'h0);
        issue(0, 1'b0, DM_LBU, 32'h5, 32'h0);
      end
      issue(1, 1'b0, DM_LHU, 32'h8, 32'h0);
    join
    repeat (10) @(posedge clk);
    #1;
    check("arb_count", 32'(acc_log.size()), 3);
    if (acc_log.size() == 3) begin
      check("arb_first", 32'(acc_log[0]), 0);
      check("arb_second", 32'(acc_log[1]), 1);
      check("arb_third", 32'(acc_log[2]), 0);
    end

    // Word store then reads of every width.
    issue(0, 1'b1, DM_LW, 32'h10, 32'hDEADBEEF);
    await_done(0, "sw", 1'b0, rd_model[0]);
    issue(0, 1'b0, DM_LW, 32'h10, 32'h0);
    await_done(0, "lw", 1'b0, 32'hDEADBEEF);
    issue(0, 1'b0, DM_LB, 32'h13, 32'h0);
    await_done(0, "lb", 1'b0, 32'hFFFFFFDE);
    issue(0, 1'b0, DM_LBU, 32'h13, 32'h0);
    await_done(0, "lbu", 1'b0, 32'h000000DE);
    issue(0, 1'b0, DM_LH, 32'h12, 32'h0);
    await_done(0, "lh", 1'b0, 32'hFFFFDEAD);
    issue(0, 1'b0, DM_LHU, 32'h12, 32'h0);
    await_done(0, "lhu", 1'b0, 32'h0000DEAD);
    issue(0, 1'b0, DM_LH, 32'h11, 32'h0);
    await_done(0, "lh_misaligned", 1'b0, 32'hFFFFADBE);

    // Rejected accesses leave rdata alone.
    issue(0, 1'b0, DM_LW, 32'h7E, 32'h0);
    await_done(0, "err_cross_end", 1'b1, 32'hFFFFADBE);
    issue(0, 1'b0, 3'b011, 32'h10, 32'h0);
    await_done(0, "err_ctrl011", 1'b1, 32'hFFFFADBE);
    issue(0, 1'b1, DM_LBU, 32'h10, 32'h12345678);
    await_done(0, "err_store_unsigned", 1'b1, 32'hFFFFADBE);
    issue(0, 1'b0, DM_LW, 32'h80, 32'h0);
    await_done(0, "err_addr80", 1'b1, 32'hFFFFADBE);
    issue(0, 1'b0, DM_LW, 32'h7C, 32'h0);
    await_done(0, "lw_top_word", 1'b0, {ref_mem[127], ref_mem[126], ref_mem[125], ref_mem[124]});

    // Reset during the second byte of a word store.
    old_word = {ref_mem[8'h23], ref_mem[8'h22], ref_mem[8'h21], ref_mem[8'h20]};
    issue(0, 1'b1, DM_LW, 32'h20, 32'h11223344);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("midop_reset");
    flush_model();
    ref_mem[8'h20] = 8'h44;
    ref_mem[8'h21] = old_word[15:8];
    ref_mem[8'h22] = old_word[23:16];
    ref_mem[8'h23] = old_word[31:24];
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    issue(0, 1'b0, DM_LW, 32'h20, 32'h0);
    await_done(0, "partial_word", 1'b0, {old_word[31:8], 8'h44});

    // Randomised traffic on both ports at once.
    fork
      for (int i = 0; i < 40; i++) rand_op(0);
      for (int j = 0; j < 40; j++) rand_op(1);
    join

    drained = 0;
    for (int t = 0; t < 200 && !drained; t++) begin
      @(posedge clk);
      drained = (rsp_cpu.size() == 0) && (rsp_dbg.size() == 0) && (wr_q.size() == 0);
    end
    if (!drained) fail_now("drain");
    #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
